wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file write port.
- Accepts write requests from two producers, the ALU result path and the ID-stage immediate/load path, each with a valid/ready handshake.
- Buffers requests in program order in a small FIFO and drains one per cycle onto the register file's w_addr/w_enable/w_select/w_alu/w_id inputs.
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_fifo.sv | 61 ++++++
 rtl/wb_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and the queued write-entry type for the writeback stage.
package wb_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 3;
   localparam int NREGS  = 1 << ADDR_W;

   // Source encoding matches the register file's w_select input.
   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_ID  = 1'b1;

   typedef struct packed {
      logic              src;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Single-push / single-pop synchronous FIFO of writeback entries.
// The head entry is read combinationally from registered storage so the
// register file sees it in the same cycle it is popped.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  wb_entry_t        push_entry,
   input  logic             pop,
   output wb_entry_t        head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= push_entry;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin merge of the ALU and ID write requests into
// an in-order FIFO that drains one entry per cycle into the register file,
// plus a per-register pending-write scoreboard for RAW hazard detection.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [ADDR_W-1:0] id_addr,
   input  logic [DATA_W-1:0] id_data,
   input  logic              wb_hold,
   output logic              w_enable,
   output logic [ADDR_W-1:0] w_addr,
   output logic              w_select,
   output logic [DATA_W-1:0] w_alu,
   output logic [DATA_W-1:0] w_id,
   output logic [NREGS-1:0]  busy,
   input  logic [ADDR_W-1:0] q_addr_0,
   input  logic [ADDR_W-1:0] q_addr_1,
   output logic              q_busy_0,
   output logic              q_busy_1,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full
);

   logic      rr_reg;        // source that wins the next conflict
   logic      fifo_full;
   logic      fifo_empty;
   logic      push;
   logic      pop;
   logic      conflict;
   wb_entry_t push_entry;
   wb_entry_t head;

   // Grant: no acceptance while full or in reset; rr decides only on conflict.
   always_comb begin
      alu_ready = 1'b0;
      id_ready  = 1'b0;
      if (!rst && !fifo_full) begin
         if (alu_valid && id_valid) begin
            alu_ready = (rr_reg == SRC_ALU);
            id_ready  = (rr_reg == SRC_ID);
         end else begin
            alu_ready = alu_valid;
            id_ready  = id_valid;
         end
      end
   end

   assign push     = alu_ready || id_ready;
   assign conflict = alu_valid && id_valid && push;

   // Build the entry for whichever source was granted.
   always_comb begin
      push_entry.src  = SRC_ALU;
      push_entry.addr = alu_addr;
      push_entry.data = alu_data;
      if (id_ready) begin
         push_entry.src  = SRC_ID;
         push_entry.addr = id_addr;
         push_entry.data = id_data;
      end
   end

   // Round-robin pointer flips only after a conflicted grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_reg <= SRC_ALU;
      end else if (conflict) begin
         rr_reg <= ~rr_reg;
      end
   end

   wb_fifo #(
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_entry(push_entry),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // The pop coincides with the register-file write; suppressed during reset.
   assign pop      = !rst && !fifo_empty && !wb_hold;
   assign w_enable = pop;
   assign w_addr   = fifo_empty ? '0 : head.addr;
   assign w_select = !fifo_empty && (head.src == SRC_ID);
   assign w_alu    = (!fifo_empty && head.src == SRC_ALU) ? head.data : '0;
   assign w_id     = (!fifo_empty && head.src == SRC_ID)  ? head.data : '0;
   assign empty    = fifo_empty;
   assign full     = fifo_full;

   // One pending-write counter per register.
   for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
      logic [CNT_W-1:0] pend_reg;
      logic             inc;
      logic             dec;

      assign inc = push && (push_entry.addr == ADDR_W'(gi));
      assign dec = pop && (head.addr == ADDR_W'(gi));

      // Same-cycle enqueue and dequeue to this register cancel out.
      always_ff @(posedge clk) begin
         if (rst) begin
            pend_reg <= '0;
         end else begin
            case ({inc, dec})
               2'b10:   pend_reg <= pend_reg + CNT_W'(1);
               2'b01:   pend_reg <= pend_reg - CNT_W'(1);
               default: pend_reg <= pend_reg;
            endcase
         end
      end

      assign busy[gi] = (pend_reg != '0);
   end

   assign q_busy_0 = busy[q_addr_0];
   assign q_busy_1 = busy[q_addr_1];

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes are queued
// as requests are issued and a monitor checks each write as it drains.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, id_valid, wb_hold;
   logic        alu_ready, id_ready;
   logic [2:0]  alu_addr, id_addr, q_addr_0, q_addr_1;
   logic [31:0] alu_data, id_data;
   logic        w_enable, w_select, q_busy_0, q_busy_1, empty, full;
   logic [2:0]  w_addr;
   logic [31:0] w_alu, w_id;
   logic [7:0]  busy;
   logic [2:0]  count;

   typedef struct {
      logic [2:0]  addr;
      logic        sel;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   wb_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .id_valid(id_valid), .id_ready(id_ready), .id_addr(id_addr), .id_data(id_data),
      .wb_hold(wb_hold), .w_enable(w_enable), .w_addr(w_addr), .w_select(w_select),
      .w_alu(w_alu), .w_id(w_id), .busy(busy),
      .q_addr_0(q_addr_0), .q_addr_1(q_addr_1), .q_busy_0(q_busy_0), .q_busy_1(q_busy_1),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_write(input logic [2:0] a, input logic s, input logic [31:0] d);
      exp_t e;
      e.addr = a;
      e.sel  = s;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty(input string name);
      int n = 0;
      while (empty !== 1'b1 && n < 10) begin
         step();
         @(negedge clk);
         n++;
      end
      chk(name, empty, 1);
   endtask

   // Monitor: every register-file write must match the oldest expected write.
   always @(negedge clk) begin
      if (w_enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {29'd0, w_addr}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("w_addr", w_addr, e.addr);
            chk("w_select", w_select, e.sel);
            chk("w_alu", w_alu, e.sel ? 32'd0 : e.data);
            chk("w_id", w_id, e.sel ? e.data : 32'd0);
            $display("[TB] write r%0d sel=%0d alu=%0h id=%0h", w_addr, w_select, w_alu, w_id);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; alu_valid = 0; id_valid = 0; wb_hold = 0;
      alu_addr = 0; id_addr = 0; alu_data = 0; id_data = 0;
      q_addr_0 = 0; q_addr_1 = 0;
      step(); step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_w_enable", w_enable, 0);
      chk("rst_busy", busy, 8'h00);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_w_alu", w_alu, 0);

      // Single ALU write
      step();
      alu_valid = 1; alu_addr = 3; alu_data = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("alu_only_alu_ready", alu_ready, 1);
      chk("alu_only_id_ready", id_ready, 0);
      expect_write(3, 0, 32'hDEAD_BEEF);
      step();
      alu_valid = 0;
      @(negedge clk);
      chk("single_busy", busy, 8'h08);
      chk("single_count", count, 1);
      step();
      @(negedge clk);
      chk("single_busy_after", busy, 8'h00);
      chk("single_empty_after", empty, 1);

      // Single ID write
      step();
      id_valid = 1; id_addr = 4; id_data = 32'h44;
      @(negedge clk);
      chk("id_only_id_ready", id_ready, 1);
      chk("id_only_alu_ready", alu_ready, 0);
      expect_write(4, 1, 32'h44);
      step();
      id_valid = 0;
      @(negedge clk);
      wait_empty("id_drain");

      // Conflict round-robin with draining held
      for (int i = 0; i < 4; i++) begin
         step();
         wb_hold = 1; alu_valid = 1; id_valid = 1;
         alu_addr = 1; id_addr = 2;
         alu_data = 32'hA0 + i; id_data = 32'hB0 + i;
         @(negedge clk);
         chk("rr_alu_ready", alu_ready, (i % 2 == 0) ? 1 : 0);
         chk("rr_id_ready", id_ready, (i % 2 == 1) ? 1 : 0);
         if (i % 2 == 0) expect_write(1, 0, 32'hA0 + i);
         else            expect_write(2, 1, 32'hB0 + i);
      end
      step();
      alu_data = 32'hA4; id_data = 32'hB4;
      @(negedge clk);
      chk("full_flag", full, 1);
      chk("full_alu_ready", alu_ready, 0);
      chk("full_id_ready", id_ready, 0);
      chk("full_busy", busy, 8'h06);
      chk("full_count", count, 4);

      // Full with simultaneous pop: no bypass
      step();
      wb_hold = 0; id_valid = 0; alu_addr = 7; alu_data = 32'h77;
      @(negedge clk);
      chk("fullpop_alu_ready", alu_ready, 0);
      chk("fullpop_count4", count, 4);
      step();
      @(negedge clk);
      chk("fullpop_alu_ready_next", alu_ready, 1);
      chk("fullpop_count3", count, 3);
      expect_write(7, 0, 32'h77);
      step();
      alu_valid = 0;
      @(negedge clk);
      chk("fullpop_count3_again", count, 3);
      wait_empty("fullpop_drain");

      // WAW on r5 with hazard queries
      step();
      wb_hold = 1; alu_valid = 1; alu_addr = 5; alu_data = 32'd1;
      q_addr_0 = 5; q_addr_1 = 3;
      @(negedge clk);
      chk("waw_q0_before", q_busy_0, 0);
      chk("waw_alu_ready", alu_ready, 1);
      expect_write(5, 0, 32'd1);
      step();
      alu_valid = 0; id_valid = 1; id_addr = 5; id_data = 32'd2;
      @(negedge clk);
      chk("waw_q0_pend1", q_busy_0, 1);
      chk("waw_count1", count, 1);
      chk("waw_id_ready", id_ready, 1);
      expect_write(5, 1, 32'd2);
      step();
      id_valid = 0; wb_hold = 0;
      @(negedge clk);
      chk("waw_q0_pend2", q_busy_0, 1);
      chk("waw_busy", busy, 8'h20);
      chk("waw_q1", q_busy_1, 0);
      chk("waw_count2", count, 2);
      step();
      @(negedge clk);
      chk("waw_q0_pend1b", q_busy_0, 1);
      chk("waw_count1b", count, 1);
      step();
      @(negedge clk);
      chk("waw_q0_pend0", q_busy_0, 0);
      chk("waw_empty", empty, 1);

      // Reset mid-operation; pre-fill leaves rr pointing at ID
      step();
      wb_hold = 1; alu_valid = 1; id_valid = 1;
      alu_addr = 6; id_addr = 6; alu_data = 32'h61; id_data = 32'h69;
      @(negedge clk);
      chk("prefill_alu_ready", alu_ready, 1);
      chk("prefill_id_ready", id_ready, 0);
      step();
      id_valid = 0; alu_data = 32'h62;
      step();
      alu_data = 32'h63;
      @(negedge clk);
      chk("prefill_count2", count, 2);
      step();
      alu_valid = 0;
      @(negedge clk);
      chk("prefill_count3", count, 3);
      chk("prefill_busy", busy, 8'h40);
      step();
      rst = 1; wb_hold = 0;
      @(negedge clk);
      chk("midrst_w_enable", w_enable, 0);
      step();
      rst = 0;
      @(negedge clk);
      chk("postrst_count", count, 0);
      chk("postrst_busy", busy, 8'h00);
      chk("postrst_empty", empty, 1);
      chk("postrst_w_enable", w_enable, 0);
      chk("postrst_w_addr", w_addr, 0);
      chk("postrst_w_select", w_select, 0);
      chk("postrst_w_id", w_id, 0);

      // After reset rr is ALU-first again
      step();
      alu_valid = 1; id_valid = 1;
      alu_addr = 0; id_addr = 1; alu_data = 32'h1234; id_data = 32'h5678;
      @(negedge clk);
      chk("postrst_rr_alu", alu_ready, 1);
      chk("postrst_rr_id", id_ready, 0);
      expect_write(0, 0, 32'h1234);
      step();
      alu_valid = 0;
      @(negedge clk);
      chk("postrst_id_ready", id_ready, 1);
      expect_write(1, 1, 32'h5678);
      step();
      id_valid = 0;
      @(negedge clk);
      wait_empty("final_drain");
      step();
      @(negedge clk);
      chk("pending_expected_writes", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
